reg_file_multi: RTL

//  Parametrised architectural register file with per-register rename tags (Tomasulo

---
 rtl/reg_file_multi.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/reg_file_multi.sv
// ----------------------------------------------------------------------------
// reg_file_multi
//   Architectural register file with per-register rename tags for the
//   out-of-order core (Tomasulo style). It sits between the decoder and the
//   issue/RS stage.
//
//   Each register holds a data word and a producer tag. A tag of TAG_INVALID
//   means the data word is the architectural value. Any other tag names the
//   ROB entry that will produce the value. Register 0 is hardwired to zero
//   and is never renamed.
//
// Ports
//   clk        clock
//   rst_n      asynchronous active-low reset
//   flush      clear every tag on mispredict; data is kept
//   rs_addr    NUM_RD read addresses, port i at [i*AW +: AW]
//   rs_val     NUM_RD read data words (combinational)
//   rs_tag     NUM_RD producer tags; TAG_INVALID means rs_val is valid
//   ren_valid  allocate a destination register this cycle
//   ren_rd     destination register being renamed
//   ren_tag    ROB tag assigned to ren_rd
//   wb_valid   NUM_WB write-back channel valids
//   wb_rd      write-back destination registers
//   wb_tag     write-back producer tags
//   wb_data    write-back results
//   busy_cnt   registered count of registers whose tag is not TAG_INVALID
//
// Configuration
//   REG_FILE_WB_BYPASS_EN  When this is defined, a read port forwards a
//                          same-cycle write-back whose tag matches the
//                          stored tag. When it is undefined, a write-back
//                          becomes readable in the cycle after the clock edge.
// ----------------------------------------------------------------------------
module reg_file_multi #(
    parameter int               NUM_REGS    = 32,
    parameter int               DATA_W      = 32,
    parameter int               TAG_W       = 4,
    parameter logic [TAG_W-1:0] TAG_INVALID = '1,
    parameter int               NUM_RD      = 2,
    parameter int               NUM_WB      = 2,
    parameter int               AW          = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [NUM_RD*AW-1:0]       rs_addr,
    output logic [NUM_RD*DATA_W-1:0]   rs_val,
    output logic [NUM_RD*TAG_W-1:0]    rs_tag,
    input  logic                       ren_valid,
    input  logic [AW-1:0]              ren_rd,
    input  logic [TAG_W-1:0]           ren_tag,
    input  logic [NUM_WB-1:0]          wb_valid,
    input  logic [NUM_WB*AW-1:0]       wb_rd,
    input  logic [NUM_WB*TAG_W-1:0]    wb_tag,
    input  logic [NUM_WB*DATA_W-1:0]   wb_data,
    output logic [AW:0]                busy_cnt
);

    localparam logic [AW:0] BUSY_ONE = 1;

    logic [DATA_W-1:0] data_q   [NUM_REGS];
    logic [TAG_W-1:0]  tag_q    [NUM_REGS];
    logic [DATA_W-1:0] data_nxt [NUM_REGS];
    logic [TAG_W-1:0]  tag_nxt  [NUM_REGS];
    logic [AW:0]       busy_nxt;

    // Next-state computation.
    // Write-back channels are matched against the tags from before this edge.
    // The channels are scanned from the highest index down, so the lowest
    // matching channel is applied last and wins.
    // Rename is applied after write-back, so a rename in the same cycle takes
    // the tag. Flush overrides every tag and drops the rename.
    // Register 0 is never updated.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            data_nxt[r] = data_q[r];
            tag_nxt[r]  = tag_q[r];
        end
        for (int r = 1; r < NUM_REGS; r++) begin
            for (int k = NUM_WB - 1; k >= 0; k--) begin
                if (wb_valid[k] && (wb_rd[k*AW +: AW] == AW'(r)) &&
                    (wb_tag[k*TAG_W +: TAG_W] == tag_q[r])) begin
                    data_nxt[r] = wb_data[k*DATA_W +: DATA_W];
                    tag_nxt[r]  = TAG_INVALID;
                end
            end
            if (flush) begin
                tag_nxt[r] = TAG_INVALID;
            end else if (ren_valid && (ren_rd == AW'(r))) begin
                tag_nxt[r] = ren_tag;
            end
        end
        busy_nxt = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (tag_nxt[r] != TAG_INVALID) begin
                busy_nxt = busy_nxt + BUSY_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                data_q[r] <= '0;
                tag_q[r]  <= TAG_INVALID;
            end
            busy_cnt <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                data_q[r] <= data_nxt[r];
                tag_q[r]  <= tag_nxt[r];
            end
            busy_cnt <= busy_nxt;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] val;
        logic [TAG_W-1:0]  tag;

        assign addr = rs_addr[i*AW +: AW];

        always_comb begin
            val = data_q[addr];
            tag = tag_q[addr];
`ifdef REG_FILE_WB_BYPASS_EN
            for (int k = NUM_WB - 1; k >= 0; k--) begin
                if (wb_valid[k] && (wb_rd[k*AW +: AW] == addr) &&
                    (wb_tag[k*TAG_W +: TAG_W] == tag_q[addr])) begin
                    val = wb_data[k*DATA_W +: DATA_W];
                    tag = TAG_INVALID;
                end
            end
`endif
            // Register 0 always reads as zero and ready.
            // Gating on rst_n also stops forwarding while reset is asserted.
            if (!rst_n || (addr == '0)) begin
                val = '0;
                tag = TAG_INVALID;
            end
        end

        assign rs_val[i*DATA_W +: DATA_W] = val;
        assign rs_tag[i*TAG_W +: TAG_W]   = tag;
    end

endmodule
